exec_stage: RTL and testbench
=============================

EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of operands and results.
REQ-002 Parameter MUL_CYCLES, default 32, iterations of the shift-add multiplier; equals XLEN.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  decoded bundle present on the alu_op/rd/op1/op2/imm_data/reg_wr_en/imm_flag inputs.
REQ-006 in_ready  out  1  stage accepts the bundle this cycle.
REQ-007 alu_op  in  4  operation code from the decode pipeline register.
REQ-008 rd  in  5  destination register index.
REQ-009 op1  in  XLEN  operand A.
REQ-010 op2  in  XLEN  operand B when imm_flag=0.
REQ-011 imm_data  in  XLEN  operand B when imm_flag=1.
REQ-012 imm_flag  in  1  operand-B select.
REQ-013 reg_wr_en  in  1  instruction writes a register.
REQ-014 flush  in  1  synchronous abort of the in-flight operation.
REQ-015 wb_valid  out  1  one-cycle pulse: writeback bundle valid.
REQ-016 wb_en  out  1  register-file write enable, qualified by wb_valid.
REQ-017 wb_rd  out  5  writeback index.
REQ-018 wb_data  out  XLEN  writeback result.
REQ-019 busy  out  1  multiplier iteration in progress.

Function
REQ-020 Accept occurs on a rising edge where in_valid=1, in_ready=1, flush=0.
REQ-021 in_ready = 1 in IDLE, 0 in MUL_BUSY; purely from state.
REQ-022 States IDLE, MUL_BUSY; IDLE->MUL_BUSY on accept of MUL; MUL_BUSY->IDLE on final iteration or flush.
REQ-023 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low XLEN bits), 11 PASSB; 12-15 reserved.
REQ-024 Operand B = imm_flag ? imm_data : op2; shift amount = B[4:0]; ADD/SUB/MUL wrap modulo 2^XLEN, no overflow flag.
REQ-025 Non-MUL accept: on that same edge wb_valid<=1, wb_data<=result, wb_rd<=rd; latency one cycle, back-to-back every cycle.
REQ-026 wb_en = reg_wr_en AND (rd != 0) AND opcode not reserved; reserved opcode still pulses wb_valid with wb_data=0.
REQ-027 MUL accept latches op1, B, rd, wb-enable; iteration counter cleared to 0; busy=1 next cycle.
REQ-028 Each MUL_BUSY edge adds (multiplicand << count) when multiplier bit[count]=1, count increments.
REQ-029 On the edge with count = MUL_CYCLES-1: wb_valid<=1 with product, state IDLE, busy=0; wb_valid visible MUL_CYCLES cycles after accept edge.
REQ-030 wb_valid deasserts after one cycle unless a new accept or MUL completion occurs on the next edge.
REQ-031 flush=1: no accept that edge; MUL_BUSY->IDLE, counter cleared, no wb_valid for the aborted op; flush wins over simultaneous in_valid and over the final-iteration edge.
REQ-032 flush in IDLE has no effect beyond blocking acceptance; wb_valid already high drops on the next edge as normal.
REQ-033 in_valid while in_ready=0: bundle ignored; upstream holds it stable until accepted.

Reset
REQ-034 rst_n=0 immediately forces: state IDLE, counter 0, wb_valid 0, wb_en 0, wb_rd 0, wb_data 0, busy 0, in_ready 1 once rst_n=1.
REQ-035 Reset during MUL_BUSY discards the operation; no writeback follows deassertion.
REQ-036 Reset deassertion takes effect on the next rising clk; first accept possible on that edge.

Structure
REQ-037 Shared package exec_pkg holds the alu_op enum, XLEN default and the state enum; the decode stage imports the same opcode enum.
REQ-038 Combinational ALU is sub-module exec_alu (alu_op, a, b -> result, is_reserved); sequencing, multiplier and writeback registers remain in exec_stage.

Verification
REQ-039 ADD op1=5, op2=7, imm_flag=0, rd=3, reg_wr_en=1 -> next cycle wb_valid=1, wb_data=12, wb_rd=3, wb_en=1.
REQ-040 SRA op1=0x80000000, imm_data=4, imm_flag=1 -> wb_data=0xF8000000; SLT -1 vs 1 -> 1; SLTU same -> 0.
REQ-041 MUL op1=0x12345678, op2=0x10 -> in_ready low 32 cycles, busy high, wb_data=0x23456780 on cycle 32, in_ready high same cycle.
REQ-042 ADD with rd=0, reg_wr_en=1 -> wb_valid=1, wb_en=0; opcode 13 -> wb_valid=1, wb_en=0, wb_data=0.
REQ-043 MUL then flush at iteration 10 -> no wb_valid, in_ready=1 next cycle; following ADD 1+1 -> wb_data=2.
REQ-044 rst_n pulled low mid-MUL between edges -> outputs zero immediately; after release no stale writeback, fresh SUB 3-5 -> 0xFFFFFFFE.

Source files
------------

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared opcode, state and width definitions for the execute stage
//
// Contents:
//   XLEN_DEF       default datapath width
//   alu_op_e       4-bit opcode enum (12-15 reserved); also imported by decode
//   exec_state_e   execute-stage sequencer states
//   op_is_reserved true for opcodes outside the defined set
package exec_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLT   = 4'd5,
        OP_SLTU  = 4'd6,
        OP_SLL   = 4'd7,
        OP_SRL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_MUL   = 4'd10,
        OP_PASSB = 4'd11
    } alu_op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } exec_state_e;

    function automatic logic op_is_reserved(input logic [3:0] op);
        return (op >= 4'd12);
    endfunction

endpackage

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - single-cycle combinational ALU for the execute stage
//
// Ports:
//   alu_op      in   4     operation code
//   a           in   XLEN  operand A
//   b           in   XLEN  operand B (already muxed between register and immediate)
//   result      out  XLEN  operation result; 0 for MUL (handled by the sequencer) and reserved codes
//   is_reserved out  1     opcode is in the reserved range 12-15
module exec_alu
    import exec_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            is_reserved
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] w_shamt;

    assign w_shamt = b[SHW-1:0];

    always_comb begin
        result      = '0;
        is_reserved = op_is_reserved(alu_op);
        case (alu_op)
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
            OP_SLL:   result = a << w_shamt;
            OP_SRL:   result = a >> w_shamt;
            OP_SRA:   result = $unsigned($signed(a) >>> w_shamt);
            OP_PASSB: result = b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - execute stage: 1-cycle ALU ops plus iterative shift-add multiplier
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid        decoded bundle present
//   in_ready        stage can accept (IDLE only)
//   alu_op, rd      opcode and destination index
//   op1, op2        operands A and B
//   imm_data        operand B when imm_flag=1
//   imm_flag        operand-B select
//   reg_wr_en       instruction writes a register
//   flush           abort in-flight multiply and block acceptance this edge
//   wb_valid        one-cycle writeback pulse
//   wb_en           register write enable, qualified by wb_valid
//   wb_rd, wb_data  writeback index and result
//   busy            multiply iteration in progress
module exec_stage
    import exec_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int MUL_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [XLEN-1:0] imm_data,
    input  logic            imm_flag,
    input  logic            reg_wr_en,
    input  logic            flush,
    output logic            wb_valid,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            busy
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    exec_state_e     r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_acc;
    logic [4:0]      r_mul_rd;
    logic            r_mul_wen;
    logic            r_wb_valid;
    logic            r_wb_en;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;

    logic [XLEN-1:0] w_opb;
    logic [XLEN-1:0] w_alu_res;
    logic            w_alu_rsvd;
    logic            w_accept;
    logic            w_is_mul;
    logic            w_wen;
    logic [XLEN-1:0] w_acc_next;
    logic            w_last;

    assign w_opb    = imm_flag ? imm_data : op2;
    assign w_accept = in_valid && (r_state == ST_IDLE) && !flush;
    assign w_is_mul = (alu_op == OP_MUL);
    assign w_wen    = reg_wr_en && (rd != 5'd0) && !w_alu_rsvd;

    // The multiplicand shifts left and the multiplier right each iteration,
    // so bit 0 of r_mplier is multiplier bit[count] and r_mcand is
    // multiplicand << count without a barrel shifter.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last     = (r_cnt == CW'(MUL_CYCLES - 1));

    exec_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .alu_op      (alu_op),
        .a           (op1),
        .b           (w_opb),
        .result      (w_alu_res),
        .is_reserved (w_alu_rsvd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_mul_rd   <= '0;
            r_mul_wen  <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_en    <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_mcand   <= op1;
                            r_mplier  <= w_opb;
                            r_acc     <= '0;
                            r_cnt     <= '0;
                            r_mul_rd  <= rd;
                            r_mul_wen <= w_wen;
                            r_state   <= ST_MUL_BUSY;
                        end else begin
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= w_alu_res;
                            r_wb_rd    <= rd;
                            r_wb_en    <= w_wen;
                        end
                    end
                end
                ST_MUL_BUSY: begin
                    // Flush beats the final iteration: the product is dropped.
                    if (flush) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_state    <= ST_IDLE;
                            r_cnt      <= '0;
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= w_acc_next;
                            r_wb_rd    <= r_mul_rd;
                            r_wb_en    <= r_mul_wen;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready = (r_state == ST_IDLE);
    assign busy     = (r_state == ST_MUL_BUSY);
    assign wb_valid = r_wb_valid;
    assign wb_en    = r_wb_valid && r_wb_en;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - self-checking bench for exec_stage
module tb_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm_data;
    logic        imm_flag;
    logic        reg_wr_en;
    logic        flush;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;

    exec_stage #(.XLEN(32), .MUL_CYCLES(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .rd        (rd),
        .op1       (op1),
        .op2       (op2),
        .imm_data  (imm_data),
        .imm_flag  (imm_flag),
        .reg_wr_en (reg_wr_en),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        iflag;
        logic        wen;
        logic [31:0] exp_data;
        logic        exp_en;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        en;
    } sb_t;

    sb_t sb[$];
    vec_t vecs[17];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one bundle, waiting (bounded) for in_ready; optionally queue its writeback.
    task automatic issue(input logic [3:0] op, input logic [4:0] r, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic iflag,
                         input logic wen, input logic push, input logic [31:0] exp_data,
                         input logic exp_en);
        int k;
        sb_t e;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_wait: got in_ready=0 expected 1 within 64 cycles");
        end
        alu_op = op; rd = r; op1 = a; op2 = b; imm_data = imm; imm_flag = iflag;
        reg_wr_en = wen; in_valid = 1'b1;
        if (push) begin
            e.rd = r; e.data = exp_data; e.en = exp_en;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && wb_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_wb: got wb_valid=1 rd=%0d data=%h expected no writeback",
                             wb_rd, wb_data);
                end else begin
                    e = sb.pop_front();
                    chk("wb_data", wb_data, e.data);
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_en", 32'(wb_en), 32'(e.en));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] ra;
        logic [31:0] rb;
        int k;

        rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; rd = '0; op1 = '0; op2 = '0;
        imm_data = '0; imm_flag = 1'b0; reg_wr_en = 1'b0; flush = 1'b0;

        vecs[0]  = '{4'd0,  5'd3,  32'd5,        32'd7,        32'd0,      1'b0, 1'b1, 32'd12,       1'b1};
        vecs[1]  = '{4'd1,  5'd4,  32'd3,        32'd5,        32'd0,      1'b0, 1'b1, 32'hFFFFFFFE, 1'b1};
        vecs[2]  = '{4'd2,  5'd5,  32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,      1'b0, 1'b1, 32'h00F000F0, 1'b1};
        vecs[3]  = '{4'd3,  5'd6,  32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,      1'b0, 1'b1, 32'hFFF0FFF0, 1'b1};
        vecs[4]  = '{4'd4,  5'd7,  32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,      1'b0, 1'b1, 32'hFF00FF00, 1'b1};
        vecs[5]  = '{4'd5,  5'd8,  32'hFFFFFFFF, 32'd1,        32'd0,      1'b0, 1'b1, 32'd1,        1'b1};
        vecs[6]  = '{4'd6,  5'd9,  32'hFFFFFFFF, 32'd1,        32'd0,      1'b0, 1'b1, 32'd0,        1'b1};
        vecs[7]  = '{4'd9,  5'd10, 32'h80000000, 32'd0,        32'd4,      1'b1, 1'b1, 32'hF8000000, 1'b1};
        vecs[8]  = '{4'd8,  5'd11, 32'h80000000, 32'd4,        32'd0,      1'b0, 1'b1, 32'h08000000, 1'b1};
        vecs[9]  = '{4'd7,  5'd12, 32'd1,        32'h21,       32'd0,      1'b0, 1'b1, 32'd2,        1'b1};
        vecs[10] = '{4'd11, 5'd13, 32'd0,        32'd123,      32'hABCD,   1'b1, 1'b1, 32'hABCD,     1'b1};
        vecs[11] = '{4'd0,  5'd14, 32'hFFFFFFFF, 32'd1,        32'd0,      1'b0, 1'b1, 32'd0,        1'b1};
        vecs[12] = '{4'd0,  5'd0,  32'd5,        32'd7,        32'd0,      1'b0, 1'b1, 32'd12,       1'b0};
        vecs[13] = '{4'd13, 5'd7,  32'd5,        32'd7,        32'd0,      1'b0, 1'b1, 32'd0,        1'b0};
        vecs[14] = '{4'd4,  5'd5,  32'd1,        32'd3,        32'd0,      1'b0, 1'b0, 32'd2,        1'b0};
        vecs[15] = '{4'd5,  5'd15, 32'd1,        32'hFFFFFFFF, 32'd0,      1'b0, 1'b1, 32'd0,        1'b1};
        vecs[16] = '{4'd0,  5'd31, 32'd10,       32'd999,      32'd20,     1'b1, 1'b1, 32'd30,       1'b1};

        // Reset values while rst_n is low.
        #3;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single-cycle ops back to back.
        for (int i = 0; i < 17; i++)
            issue(vecs[i].op, vecs[i].rd, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].iflag,
                  vecs[i].wen, 1'b1, vecs[i].exp_data, vecs[i].exp_en);
        repeat (3) @(negedge clk);
        chk("vec_drained", 32'(sb.size()), 32'd0);

        // MUL latency: in_ready low for 32 cycles, result with in_ready high.
        issue(4'd10, 5'd20, 32'h12345678, 32'h10, 32'd0, 1'b0, 1'b1, 1'b1, 32'h23456780, 1'b1);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk($sformatf("mul_in_ready_c%0d", i), 32'(in_ready), 32'd0);
            chk($sformatf("mul_busy_c%0d", i), 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("mul_done_valid", 32'(wb_valid), 32'd1);
        chk("mul_done_in_ready", 32'(in_ready), 32'd1);
        chk("mul_done_busy", 32'(busy), 32'd0);

        // Random MULs, immediate MUL, rd=0 MUL; bench computes products directly.
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            issue(4'd10, 5'(i + 1), ra, rb, 32'd0, 1'b0, 1'b1, 1'b1, ra * rb, 1'b1);
        end
        issue(4'd10, 5'd17, 32'd7, 32'd1000, 32'd6, 1'b1, 1'b1, 1'b1, 32'd42, 1'b1);
        issue(4'd10, 5'd0, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b1, 32'd81, 1'b0);

        // Bundle held valid while busy is accepted only after the MUL completes.
        issue(4'd10, 5'd21, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 1'b1, 32'd42, 1'b1);
        @(negedge clk);
        alu_op = 4'd1; rd = 5'd22; op1 = 32'd100; op2 = 32'd1; imm_flag = 1'b0;
        reg_wr_en = 1'b1; in_valid = 1'b1;
        sb.push_back('{5'd22, 32'd99, 1'b1});
        k = 0;
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("held_ready_seen", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mul_drained", 32'(sb.size()), 32'd0);

        // Flush at iteration 10: no writeback, then ADD 1+1.
        issue(4'd10, 5'd23, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush10_in_ready", 32'(in_ready), 32'd1);
        chk("flush10_busy", 32'(busy), 32'd0);
        chk("flush10_wb_valid", 32'(wb_valid), 32'd0);
        repeat (40) @(negedge clk);
        issue(4'd0, 5'd24, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b1, 32'd2, 1'b1);

        // Flush on the final-iteration edge drops the product.
        issue(4'd10, 5'd25, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        repeat (31) @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_last_wb_valid", 32'(wb_valid), 32'd0);
        chk("flush_last_in_ready", 32'(in_ready), 32'd1);
        repeat (5) @(negedge clk);

        // Flush in IDLE blocks a simultaneous in_valid.
        alu_op = 4'd0; rd = 5'd26; op1 = 32'd4; op2 = 32'd4; reg_wr_en = 1'b1;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin in_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        chk("flush_idle_wb_valid", 32'(wb_valid), 32'd0);

        // Reset mid-MUL between edges clears everything; no stale writeback.
        issue(4'd0, 5'd6, 32'd4, 32'd4, 32'd0, 1'b0, 1'b1, 1'b1, 32'd8, 1'b1);
        issue(4'd10, 5'd27, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("mid_rst_wb_data", wb_data, 32'd0);
        chk("mid_rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (40) @(negedge clk);
        issue(4'd1, 5'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b1);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
